// File: rtl/unpool_multi_if.sv
// Flat-bus handshake bundle for the 2x2 unpooling engine.
// master: drives start/upInput; slave: returns upOutput/busy/done.
interface unpool_multi_if #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 6,
  parameter int H          = 14,
  parameter int W          = 14
);
  localparam int IN_W  = H * W * D * DATA_WIDTH;
  localparam int OUT_W = 4 * IN_W;

  logic             start;
  logic [IN_W-1:0]  upInput;
  logic [OUT_W-1:0] upOutput;
  logic             busy;
  logic             done;

  modport master (
    output start, upInput,
    input  upOutput, busy, done
  );

  modport slave (
    input  start, upInput,
    output upOutput, busy, done
  );
endinterface

// File: rtl/unpool_multi.sv
// Multi-channel 2x2 nearest-neighbour unpooling, one channel per clock.
// Ports: clk, reset (sync, active-low), bus (unpool_multi_if.slave:
//   start, upInput in; upOutput, busy, done out).
// Option: define UNPOOL_SCALE_EN to arithmetic-shift each element right by 2.
module unpool_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 6,
  parameter int H          = 14,
  parameter int W          = 14
) (
  input  logic          clk,
  input  logic          reset,
  unpool_multi_if.slave bus
);
  localparam int CH_IN  = H * W * DATA_WIDTH;
  localparam int CH_OUT = 4 * CH_IN;
  localparam int CW     = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]       ch_q;
  logic [D*CH_IN-1:0]  in_q;
  logic [D*CH_OUT-1:0] out_q;
  logic [CH_IN-1:0]    in_sel;
  logic [CH_OUT-1:0]   exp_ch;
  logic                accept;
  logic                last;

  function automatic logic [DATA_WIDTH-1:0] scale(
    input logic [DATA_WIDTH-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] s;
    s = v;
`ifdef UNPOOL_SCALE_EN
    return s >>> 2;
`else
    return s;
`endif
  endfunction

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (ch_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q <= '0;
    end else if (accept) begin
      ch_q <= '0;
    end else if (state_q == RUN) begin
      ch_q <= last ? '0 : ch_q + CW'(1);
    end
  end

  // Snapshot so upstream may move on right after start.
  always_ff @(posedge clk) begin
    if (!reset)      in_q <= '0;
    else if (accept) in_q <= bus.upInput;
  end

  always_comb begin
    in_sel = '0;
    for (int c = 0; c < D; c++) begin
      if (ch_q == CW'(c)) in_sel = in_q[c*CH_IN +: CH_IN];
    end
  end

  // Output pixel (R,K) takes input pixel (R/2,K/2).
  always_comb begin
    exp_ch = '0;
    for (int r = 0; r < 2*H; r++) begin
      for (int k = 0; k < 2*W; k++) begin
        exp_ch[(r*2*W + k)*DATA_WIDTH +: DATA_WIDTH] =
          scale(in_sel[((r/2)*W + k/2)*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Only the active channel is rewritten; others keep prior run's data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else if (state_q == RUN) begin
      for (int c = 0; c < D; c++) begin
        if (ch_q == CW'(c)) out_q[c*CH_OUT +: CH_OUT] <= exp_ch;
      end
    end
  end

  assign bus.upOutput = out_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
endmodule
